hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard.sv | 146 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks destination registers of in-flight instructions
// from DE until their value can be bypassed, and stalls FD/PC when an FD
// instruction would consume a value that is not yet forwardable.
// Per-register wait code: 0 = forwardable, 1/2 = cycles left, 3 = held for multdiv.
module hazard_scoreboard (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_en,
    input  logic        issue_wr,
    input  logic [4:0]  issue_rd,
    input  logic        issue_is_load,
    input  logic        issue_is_md,
    input  logic [4:0]  fd_rs1,
    input  logic [4:0]  fd_rs2,
    input  logic [4:0]  fd_rd,
    input  logic        fd_is_md,
    input  logic        md_done,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic        flush,
    output logic        stall,
    output logic        md_busy,
    output logic [31:0] pending_mask
);

    // Registered scoreboard state
    logic [31:0]       r_pending;
    logic [31:0][1:0]  r_wait;
    logic              r_md_busy;
    logic [4:0]        r_md_rd;
    logic              r_li_valid;
    logic [4:0]        r_li_rd;
    logic              r_li_md;

    // Next-state and decode wires
    logic [31:0]       w_pending_nxt;
    logic [31:0][1:0]  w_wait_nxt;
    logic              w_md_busy_nxt;
    logic [4:0]        w_md_rd_nxt;
    logic              w_accept;
    logic [1:0]        w_issue_wait;
    logic              w_flush_hit;
    logic              w_md_done_hit;
    logic              w_rs1_haz;
    logic              w_rs2_haz;
    logic              w_waw_haz;
    logic              w_md_struct_haz;
    logic              w_stall;

    // Hazard detection: combinational from FD fields and registered state
    always_comb begin
        w_rs1_haz       = (fd_rs1 != 5'd0) && r_pending[fd_rs1] && (r_wait[fd_rs1] != 2'd0);
        w_rs2_haz       = (fd_rs2 != 5'd0) && r_pending[fd_rs2] && (r_wait[fd_rs2] != 2'd0);
        w_waw_haz       = r_md_busy && (fd_rd != 5'd0) && (fd_rd == r_md_rd);
        w_md_struct_haz = r_md_busy && fd_is_md;
        w_stall         = w_rs1_haz || w_rs2_haz || w_waw_haz || w_md_struct_haz;
    end

    // Issue acceptance and the initial wait code of the new entry
    always_comb begin
        w_accept      = issue_en && issue_wr && (issue_rd != 5'd0) && !w_stall;
        w_flush_hit   = flush && r_li_valid;
        w_md_done_hit = md_done && r_md_busy;
        if (issue_is_md) begin
            w_issue_wait = 2'd3;
        end else if (issue_is_load) begin
            w_issue_wait = 2'd1;
        end else begin
            w_issue_wait = 2'd0;
        end
    end

    // Per-register next state: issue-set beats clears, clears beat the decrement
    always_comb begin
        w_pending_nxt = r_pending;
        w_wait_nxt    = r_wait;
        for (int r = 1; r < 32; r++) begin
            if (w_accept && (issue_rd == 5'(r))) begin
                w_pending_nxt[r] = 1'b1;
                w_wait_nxt[r]    = w_issue_wait;
            end else begin
                if ((r_wait[r] == 2'd1) || (r_wait[r] == 2'd2)) begin
                    w_wait_nxt[r] = r_wait[r] - 2'd1;
                end else begin
                    w_wait_nxt[r] = r_wait[r];
                end
                if (w_md_done_hit && (r_md_rd == 5'(r))) begin
                    w_wait_nxt[r] = 2'd0;
                end else begin
                    w_wait_nxt[r] = w_wait_nxt[r];
                end
                if ((wb_en && (wb_rd == 5'(r))) || (w_flush_hit && (r_li_rd == 5'(r)))) begin
                    w_pending_nxt[r] = 1'b0;
                    w_wait_nxt[r]    = 2'd0;
                end else begin
                    w_pending_nxt[r] = r_pending[r];
                end
            end
        end
        // Register 0 is hardwired zero and never tracked
        w_pending_nxt[0] = 1'b0;
        w_wait_nxt[0]    = 2'd0;
    end

    // Multdiv slot next state: a flush of the multdiv wins over its md_done
    always_comb begin
        w_md_busy_nxt = r_md_busy;
        w_md_rd_nxt   = r_md_rd;
        if (w_accept && issue_is_md) begin
            w_md_busy_nxt = 1'b1;
            w_md_rd_nxt   = issue_rd;
        end else if (w_flush_hit && r_li_md) begin
            w_md_busy_nxt = 1'b0;
        end else if (md_done) begin
            w_md_busy_nxt = 1'b0;
        end else begin
            w_md_busy_nxt = r_md_busy;
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pending  <= 32'd0;
            r_wait     <= '0;
            r_md_busy  <= 1'b0;
            r_md_rd    <= 5'd0;
            r_li_valid <= 1'b0;
            r_li_rd    <= 5'd0;
            r_li_md    <= 1'b0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_wait     <= w_wait_nxt;
            r_md_busy  <= w_md_busy_nxt;
            r_md_rd    <= w_md_rd_nxt;
            r_li_valid <= w_accept;
            r_li_rd    <= w_accept ? issue_rd : 5'd0;
            r_li_md    <= w_accept && issue_is_md;
        end
    end

    assign stall        = w_stall;
    assign md_busy      = r_md_busy;
    assign pending_mask = r_pending;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

    logic        clock;
    logic        reset;
    logic        issue_en;
    logic        issue_wr;
    logic [4:0]  issue_rd;
    logic        issue_is_load;
    logic        issue_is_md;
    logic [4:0]  fd_rs1;
    logic [4:0]  fd_rs2;
    logic [4:0]  fd_rd;
    logic        fd_is_md;
    logic        md_done;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        stall;
    logic        md_busy;
    logic [31:0] pending_mask;

    int checks_cnt;
    int fail_cnt;

    hazard_scoreboard dut (
        .clock         (clock),
        .reset         (reset),
        .issue_en      (issue_en),
        .issue_wr      (issue_wr),
        .issue_rd      (issue_rd),
        .issue_is_load (issue_is_load),
        .issue_is_md   (issue_is_md),
        .fd_rs1        (fd_rs1),
        .fd_rs2        (fd_rs2),
        .fd_rd         (fd_rd),
        .fd_is_md      (fd_is_md),
        .md_done       (md_done),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .flush         (flush),
        .stall         (stall),
        .md_busy       (md_busy),
        .pending_mask  (pending_mask)
    );

    // Free-running clock, 10 time-unit period
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; inputs change and outputs are sampled 1 unit after it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        issue_en = 1'b0; issue_wr = 1'b0; issue_rd = 5'd0;
        issue_is_load = 1'b0; issue_is_md = 1'b0;
        fd_rs1 = 5'd0; fd_rs2 = 5'd0; fd_rd = 5'd0; fd_is_md = 1'b0;
        md_done = 1'b0; wb_en = 1'b0; wb_rd = 5'd0; flush = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic ld, input logic md);
        issue_en = 1'b1; issue_wr = 1'b1; issue_rd = rd;
        issue_is_load = ld; issue_is_md = md;
    endtask

    task automatic no_issue();
        issue_en = 1'b0; issue_wr = 1'b0; issue_rd = 5'd0;
        issue_is_load = 1'b0; issue_is_md = 1'b0;
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        idle_inputs();
        reset = 1'b0;
        #12;
        check_val("rst_mask", pending_mask, 32'h0);
        check_val("rst_stall", {31'd0, stall}, 32'd0);
        check_val("rst_busy", {31'd0, md_busy}, 32'd0);
        reset = 1'b1;
        tick();
        check_val("rel_mask", pending_mask, 32'h0);
        check_val("rel_stall", {31'd0, stall}, 32'd0);

        // ALU producer: add $3, dependent sub never stalls
        issue(5'd3, 1'b0, 1'b0);
        tick();
        no_issue();
        fd_rs1 = 5'd3; fd_rs2 = 5'd2;
        #1;
        check_val("alu_stall0", {31'd0, stall}, 32'd0);
        check_val("alu_mask0", pending_mask, 32'h0000_0008);
        tick();
        check_val("alu_stall1", {31'd0, stall}, 32'd0);
        check_val("alu_mask1", pending_mask, 32'h0000_0008);
        wb_en = 1'b1; wb_rd = 5'd3;
        tick();
        idle_inputs();
        check_val("alu_wb_mask", pending_mask, 32'h0);

        // Load-use: lw $5 then add $6,$5,$1 stalls exactly one cycle
        issue(5'd5, 1'b1, 1'b0);
        tick();
        issue(5'd6, 1'b0, 1'b0);
        fd_rs1 = 5'd5; fd_rs2 = 5'd1; fd_rd = 5'd6;
        #1;
        check_val("ld_stall_c1", {31'd0, stall}, 32'd1);
        check_val("ld_mask_c1", pending_mask, 32'h0000_0020);
        tick();
        check_val("ld_stall_c2", {31'd0, stall}, 32'd0);
        check_val("ld_mask_c2", pending_mask, 32'h0000_0020);
        tick();
        idle_inputs();
        check_val("ld_add_issued", pending_mask, 32'h0000_0060);
        wb_en = 1'b1; wb_rd = 5'd5;
        tick();
        check_val("ld_wb5", pending_mask, 32'h0000_0040);
        wb_rd = 5'd6;
        tick();
        idle_inputs();
        check_val("ld_wb6", pending_mask, 32'h0);

        // Multdiv: mul $7, dependent held until md_done at cycle 6
        issue(5'd7, 1'b0, 1'b1);
        tick();
        no_issue();
        check_val("md_busy_set", {31'd0, md_busy}, 32'd1);
        check_val("md_mask", pending_mask, 32'h0000_0080);
        fd_rs1 = 5'd7;
        for (int c = 1; c <= 5; c++) begin
            #1;
            check_val($sformatf("md_stall_c%0d", c), {31'd0, stall}, 32'd1);
            tick();
        end
        fd_rs1 = 5'd0; fd_is_md = 1'b1;
        #1;
        check_val("md_struct_stall", {31'd0, stall}, 32'd1);
        fd_is_md = 1'b0; fd_rd = 5'd7;
        #1;
        check_val("md_waw_stall", {31'd0, stall}, 32'd1);
        fd_rd = 5'd0; fd_rs1 = 5'd7;
        md_done = 1'b1;
        #1;
        check_val("md_stall_c6", {31'd0, stall}, 32'd1);
        tick();
        md_done = 1'b0;
        #1;
        check_val("md_stall_c7", {31'd0, stall}, 32'd0);
        check_val("md_busy_c7", {31'd0, md_busy}, 32'd0);
        check_val("md_mask_c7", pending_mask, 32'h0000_0080);
        wb_en = 1'b1; wb_rd = 5'd7;
        tick();
        idle_inputs();
        check_val("md_wb_mask", pending_mask, 32'h0);

        // Flush of a load the cycle after it issued
        issue(5'd9, 1'b1, 1'b0);
        tick();
        no_issue();
        check_val("fl_mask_set", pending_mask, 32'h0000_0200);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        fd_rs1 = 5'd9;
        #1;
        check_val("fl_mask_clr", pending_mask, 32'h0);
        check_val("fl_stall", {31'd0, stall}, 32'd0);
        idle_inputs();

        // Issue and writeback to the same register: issue wins
        issue(5'd4, 1'b0, 1'b0);
        wb_en = 1'b1; wb_rd = 5'd4;
        tick();
        wb_en = 1'b0; wb_rd = 5'd0;
        check_val("iwb_mask", pending_mask, 32'h0000_0010);
        // Issue to register 0 creates nothing
        issue(5'd0, 1'b1, 1'b0);
        tick();
        no_issue();
        fd_rs1 = 5'd0; fd_rs2 = 5'd0;
        #1;
        check_val("r0_mask", pending_mask, 32'h0000_0010);
        check_val("r0_stall", {31'd0, stall}, 32'd0);
        idle_inputs();

        // Flush and md_done together on a multdiv: flush wins
        issue(5'd8, 1'b0, 1'b1);
        tick();
        no_issue();
        check_val("mdfl_busy", {31'd0, md_busy}, 32'd1);
        flush = 1'b1; md_done = 1'b1;
        tick();
        idle_inputs();
        check_val("mdfl_busy_clr", {31'd0, md_busy}, 32'd0);
        check_val("mdfl_mask", pending_mask, 32'h0000_0010);

        // Asynchronous reset in the middle of a load-use stall
        issue(5'd10, 1'b1, 1'b0);
        tick();
        no_issue();
        fd_rs1 = 5'd10;
        #1;
        check_val("ar_stall_pre", {31'd0, stall}, 32'd1);
        reset = 1'b0;
        #1;
        check_val("ar_stall", {31'd0, stall}, 32'd0);
        check_val("ar_mask", pending_mask, 32'h0);
        reset = 1'b1;
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
